// File: rtl/score_counter.sv
`default_nettype none
// ============================================================================
// Module      : score_counter
// Description : Frame-based score counter with lockout and saturation.
//               Hits and bonus hits are latched as pending flags and evaluated
//               once per frame. A scoring frame starts a lockout window of
//               LOCKOUT_FRAMES frames. Reaching MAX_SCORE parks the block in
//               FULL until a new game is requested (clearScore) or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module score_counter #(
  parameter int unsigned MAX_SCORE      = 9,   // saturation value, 1..15
  parameter int unsigned LOCKOUT_FRAMES = 4    // frames ignored after a score, 0..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       hitEvent,
  input  logic       bonusHit,
  input  logic       clearScore,
  output logic [3:0] score,
  output logic       scoreChanged,
  output logic       maxReached
);

  localparam logic [4:0] MAX_SCORE_5 = 5'(MAX_SCORE);
  localparam logic [3:0] MAX_SCORE_4 = 4'(MAX_SCORE);
  localparam logic [3:0] LOCKOUT_4   = 4'(LOCKOUT_FRAMES);

  typedef enum logic [1:0] {
    READY  = 2'd0,
    LOCKED = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] lock_count, lock_count_next;
  logic       hit_pending, hit_pending_next;
  logic       bonus_pending, bonus_pending_next;
  logic [3:0] score_next;
  logic       score_changed_next;

  logic       eff_hit;
  logic       eff_bonus;
  logic [4:0] sum;
  logic [3:0] sum_sat;

  // Events seen any time during the frame count at the boundary, as do events
  // arriving on the boundary cycle itself.
  assign eff_hit   = hit_pending   | hitEvent;
  assign eff_bonus = bonus_pending | bonusHit;

  // Saturating add in 5 bits so that e.g. 14 + 2 cannot wrap to 0.
  always_comb begin
    sum     = {1'b0, score} + (eff_bonus ? 5'd2 : 5'd1);
    sum_sat = (sum > MAX_SCORE_5) ? MAX_SCORE_4 : sum[3:0];
  end

  // Next-state logic: clearScore first, then frame evaluation, else latch events.
  always_comb begin
    state_next         = state;
    lock_count_next    = lock_count;
    hit_pending_next   = hit_pending   | hitEvent;
    bonus_pending_next = bonus_pending | bonusHit;
    score_next         = score;
    score_changed_next = 1'b0;

    if (clearScore) begin
      state_next         = READY;
      lock_count_next    = 4'd0;
      hit_pending_next   = 1'b0;
      bonus_pending_next = 1'b0;
      score_next         = 4'd0;
      score_changed_next = (score != 4'd0);
    end else if (startOfFrame) begin
      // Pending flags are always consumed at a frame boundary, used or not.
      hit_pending_next   = 1'b0;
      bonus_pending_next = 1'b0;
      case (state)
        READY: begin
          if (eff_hit || eff_bonus) begin
            score_next         = sum_sat;
            score_changed_next = (sum_sat != score);
            if (sum_sat == MAX_SCORE_4) begin
              state_next = FULL;
            end else if (LOCKOUT_FRAMES == 0) begin
              state_next = READY;
            end else begin
              state_next      = LOCKED;
              lock_count_next = LOCKOUT_4;
            end
          end
        end
        LOCKED: begin
          // Events of the frame that ends the lockout are still discarded.
          if (lock_count <= 4'd1) begin
            lock_count_next = 4'd0;
            state_next      = READY;
          end else begin
            lock_count_next = lock_count - 4'd1;
          end
        end
        FULL: begin
          state_next = FULL;
        end
        default: begin
          state_next      = READY;
          lock_count_next = 4'd0;
        end
      endcase
    end
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= READY;
      lock_count    <= 4'd0;
      hit_pending   <= 1'b0;
      bonus_pending <= 1'b0;
      score         <= 4'd0;
      scoreChanged  <= 1'b0;
      maxReached    <= 1'b0;
    end else begin
      state         <= state_next;
      lock_count    <= lock_count_next;
      hit_pending   <= hit_pending_next;
      bonus_pending <= bonus_pending_next;
      score         <= score_next;
      scoreChanged  <= score_changed_next;
      maxReached    <= (score_next == MAX_SCORE_4);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_counter
// Description : Self-checking bench for score_counter. Three instances with
//               different parameters share one stimulus stream and are each
//               compared against a score-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_counter;

  localparam int N = 3;
  localparam int P_MAX  [N] = '{9, 9, 15};
  localparam int P_LOCK [N] = '{4, 0, 2};

  logic clk = 1'b0;
  logic reset, sof, hit, bonus, clr;
  logic [3:0] score_o [N];
  logic       chg_o   [N];
  logic       max_o   [N];

  int checks = 0;
  int errors = 0;

  // Reference model: score as an integer, lockout as frames still to ignore,
  // FULL implied by score == MAX.
  int m_score [N];
  int m_lock  [N];
  bit m_hp    [N];
  bit m_bp    [N];
  bit m_chg   [N];

  always #5 clk = ~clk;

  score_counter #(.MAX_SCORE(9), .LOCKOUT_FRAMES(4)) dut0 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .hitEvent(hit),
    .bonusHit(bonus), .clearScore(clr),
    .score(score_o[0]), .scoreChanged(chg_o[0]), .maxReached(max_o[0]));

  score_counter #(.MAX_SCORE(9), .LOCKOUT_FRAMES(0)) dut1 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .hitEvent(hit),
    .bonusHit(bonus), .clearScore(clr),
    .score(score_o[1]), .scoreChanged(chg_o[1]), .maxReached(max_o[1]));

  score_counter #(.MAX_SCORE(15), .LOCKOUT_FRAMES(2)) dut2 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .hitEvent(hit),
    .bonusHit(bonus), .clearScore(clr),
    .score(score_o[2]), .scoreChanged(chg_o[2]), .maxReached(max_o[2]));

  task automatic model_step(input bit r, input bit s, input bit h, input bit b, input bit c);
    bit eh, eb;
    int ns;
    for (int k = 0; k < N; k++) begin
      if (r) begin
        m_score[k] = 0; m_lock[k] = 0; m_hp[k] = 0; m_bp[k] = 0; m_chg[k] = 0;
      end else if (c) begin
        m_chg[k] = (m_score[k] != 0);
        m_score[k] = 0; m_lock[k] = 0; m_hp[k] = 0; m_bp[k] = 0;
      end else begin
        m_chg[k] = 0;
        if (s) begin
          eh = m_hp[k] | h;
          eb = m_bp[k] | b;
          m_hp[k] = 0;
          m_bp[k] = 0;
          if (m_score[k] == P_MAX[k]) begin
            // game over until cleared
          end else if (m_lock[k] > 0) begin
            m_lock[k] = m_lock[k] - 1;
          end else if (eh || eb) begin
            ns = m_score[k] + (eb ? 2 : 1);
            if (ns > P_MAX[k]) ns = P_MAX[k];
            m_chg[k] = (ns != m_score[k]);
            m_score[k] = ns;
            if (ns != P_MAX[k]) m_lock[k] = P_LOCK[k];
          end
        end else begin
          m_hp[k] = m_hp[k] | h;
          m_bp[k] = m_bp[k] | b;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
  task automatic tick(input bit r, input bit s, input bit h, input bit b, input bit c);
    reset = r; sof = s; hit = h; bonus = b; clr = c;
    model_step(r, s, h, b, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 1, 1, 1);
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({score_o[k], chg_o[k], max_o[k]} !== 6'b0) begin
        errors++;
        $display("FAIL reset dut%0d: score=%0d chg=%0b max=%0b, required 0/0/0",
                 k, score_o[k], chg_o[k], max_o[k]);
      end
    end
  endtask

  task automatic test_long_hit;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) tick(0, 0, 1, 0, 0);
    checks++;
    if (score_o[0] !== 4'd0 || chg_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL long_hit_pre: score=%0d chg=%0b, required 0/0", score_o[0], chg_o[0]);
    end
    tick(0, 1, 0, 0, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (score_o[k] !== 4'd1 || chg_o[k] !== 1'b1) begin
        errors++;
        $display("FAIL long_hit_frame dut%0d: score=%0d chg=%0b, required 1/1", k, score_o[k], chg_o[k]);
      end
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (chg_o[0] !== 1'b0 || score_o[0] !== 4'd1) begin
      errors++;
      $display("FAIL long_hit_pulse: score=%0d chg=%0b, required 1/0", score_o[0], chg_o[0]);
    end
  endtask

  task automatic test_lockout;
    int exp0 [6] = '{1, 1, 1, 1, 1, 2};
    tick(1, 0, 0, 0, 0);
    for (int f = 0; f < 6; f++) begin
      tick(0, 0, 0, 0, 0);
      tick(0, 1, 1, 0, 0);   // hit only on the frame cycle (also covers same-cycle counting)
      checks++;
      if (score_o[0] !== 4'(exp0[f])) begin
        errors++;
        $display("FAIL lockout frame%0d: score=%0d, required %0d", f + 1, score_o[0], exp0[f]);
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({score_o[k], chg_o[k], max_o[k]} !== {4'(m_score[k]), m_chg[k], m_score[k] == P_MAX[k]}) begin
          errors++;
          $display("FAIL lockout_model dut%0d frame%0d: score=%0d chg=%0b, required %0d/%0b",
                   k, f + 1, score_o[k], chg_o[k], m_score[k], m_chg[k]);
        end
      end
    end
  endtask

  task automatic test_saturate;
    tick(1, 0, 0, 0, 0);
    for (int f = 0; f < 20 && m_score[1] < 8; f++) tick(0, 1, 1, 0, 0);
    checks++;
    if (score_o[1] !== 4'd8 || max_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL sat_pre: score=%0d max=%0b, required 8/0", score_o[1], max_o[1]);
    end
    tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 0, 0);
    checks++;
    if (score_o[1] !== 4'd9 || max_o[1] !== 1'b1 || chg_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL sat_reach: score=%0d max=%0b chg=%0b, required 9/1/1", score_o[1], max_o[1], chg_o[1]);
    end
    for (int f = 0; f < 3; f++) begin
      tick(0, 0, 1, 1, 0);
      tick(0, 1, 1, 1, 0);
      checks++;
      if (score_o[1] !== 4'd9 || chg_o[1] !== 1'b0 || max_o[1] !== 1'b1) begin
        errors++;
        $display("FAIL sat_hold: score=%0d chg=%0b max=%0b, required 9/0/1", score_o[1], chg_o[1], max_o[1]);
      end
    end
    // Bonus frames drive the 15-max instance to saturation without wrapping.
    for (int f = 0; f < 30; f++) begin
      tick(0, 1, 0, 1, 0);
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({score_o[k], chg_o[k], max_o[k]} !== {4'(m_score[k]), m_chg[k], m_score[k] == P_MAX[k]}) begin
          errors++;
          $display("FAIL sat_model dut%0d: score=%0d chg=%0b max=%0b, required %0d/%0b",
                   k, score_o[k], chg_o[k], max_o[k], m_score[k], m_chg[k]);
        end
      end
    end
    checks++;
    if (score_o[2] !== 4'd15 || max_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL sat15: score=%0d max=%0b, required 15/1", score_o[2], max_o[2]);
    end
  endtask

  task automatic test_clear;
    tick(1, 0, 0, 0, 0);
    for (int f = 0; f < 5; f++) tick(0, 1, 1, 0, 0);
    tick(0, 0, 1, 0, 0);          // leaves a hit pending
    tick(0, 1, 0, 0, 1);          // clear wins over the frame evaluation
    checks++;
    if (score_o[1] !== 4'd0 || chg_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL clear_frame: score=%0d chg=%0b, required 0/1 (from 5)", score_o[1], chg_o[1]);
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (score_o[k] !== 4'd0 || chg_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL clear_pending dut%0d: score=%0d chg=%0b, required 0/0", k, score_o[k], chg_o[k]);
      end
    end
    // Held clear ignores events and does not pulse on an already-zero score.
    for (int i = 0; i < 4; i++) begin
      tick(0, i[0], 1, 1, 1);
      checks++;
      if (score_o[1] !== 4'd0 || chg_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL clear_hold: score=%0d chg=%0b, required 0/0", score_o[1], chg_o[1]);
      end
    end
  endtask

  task automatic test_reset_locked;
    tick(1, 0, 0, 0, 0);
    for (int f = 0; f < 40 && !(m_score[0] == 3 && m_lock[0] > 0); f++) tick(0, 1, 1, 0, 0);
    checks++;
    if (score_o[0] !== 4'd3) begin
      errors++;
      $display("FAIL rst_locked_pre: score=%0d, required 3", score_o[0]);
    end
    tick(1, 1, 1, 0, 0);
    checks++;
    if (score_o[0] !== 4'd0 || max_o[0] !== 1'b0 || chg_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_locked: score=%0d max=%0b chg=%0b, required 0/0/0", score_o[0], max_o[0], chg_o[0]);
    end
    tick(0, 1, 1, 0, 0);
    checks++;
    if (score_o[0] !== 4'd1 || chg_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_locked_next: score=%0d chg=%0b, required 1/1", score_o[0], chg_o[0]);
    end
  endtask

  task automatic test_random;
    bit r, s, h, b, c;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 5) == 0);
      b = ($urandom_range(0, 11) == 0);
      tick(r, s, h, b, c);
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({score_o[k], chg_o[k], max_o[k]} !== {4'(m_score[k]), m_chg[k], m_score[k] == P_MAX[k]}) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: score=%0d chg=%0b max=%0b, required %0d/%0b/%0b",
                   k, i, score_o[k], chg_o[k], max_o[k], m_score[k], m_chg[k], m_score[k] == P_MAX[k]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; sof = 1'b0; hit = 1'b0; bonus = 1'b0; clr = 1'b0;
    test_reset();
    test_long_hit();
    test_lockout();
    test_saturate();
    test_clear();
    test_reset_locked();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
